edge_setup_sequencer: RTL and testbench

- Requester side of the edge_function exec/done strobe interface.
- Evaluates the three barycentric edge functions of one sample point against one triangle by issuing three back-to-back jobs to a single shared edge_function instance. The edge function is z = (c0-a0)*(b1-a1) - (c1-a1)*(b0-a0), IEEE-754 binary32.
- Collects the three results and produces a coverage (inside) flag for the rasterizer.
- Sits between triangle setup/pixel stepping and the edge_function datapath.

---
 rtl/edge_setup_sequencer.sv | 132 +++++++++++++
 tb/tb_edge_setup_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_setup_sequencer.sv
// Requester for a shared edge_function unit: runs the three barycentric edge jobs
// for one sample point, collects w0..w2 and derives the coverage flag.
module edge_setup_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit INCLUSIVE_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             start_strobe_i,
  input  logic [1:0][31:0] v0_i,
  input  logic [1:0][31:0] v1_i,
  input  logic [1:0][31:0] v2_i,
  input  logic [1:0][31:0] p_i,
  output logic             busy_o,
  output logic [1:0][31:0] ef_a_o,
  output logic [1:0][31:0] ef_b_o,
  output logic [1:0][31:0] ef_c_o,
  output logic             ef_exec_strobe_o,
  input  logic [31:0]      ef_z_i,
  input  logic             ef_done_strobe_i,
  output logic [31:0]      w0_o,
  output logic [31:0]      w1_o,
  output logic [31:0]      w2_o,
  output logic             inside_o,
  output logic             error_o,
  output logic             done_strobe_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FINISH} state_t;

  state_t                 state;
  logic [1:0]             job;
  logic [CW-1:0]          tmo_cnt;
  logic [2:0][1:0][31:0]  vtx;
  logic [2:0][31:0]       w_q;
  logic [2:0]             nneg, npos;
  logic                   inside_calc;

  assign w0_o = w_q[0];
  assign w1_o = w_q[1];
  assign w2_o = w_q[2];

  // Sign test on raw bits: magnitude zero is "zero" regardless of sign bit.
  always_comb begin
    nneg = '0;
    npos = '0;
    for (int i = 0; i < 3; i++) begin
      nneg[i] = (~w_q[i][31] & (|w_q[i][30:0])) | (~(|w_q[i][30:0]) & INCLUSIVE_ZERO);
      npos[i] = ( w_q[i][31] & (|w_q[i][30:0])) | (~(|w_q[i][30:0]) & INCLUSIVE_ZERO);
    end
    inside_calc = ~error_o & ((&nneg) | (&npos));
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state            <= IDLE;
      job              <= '0;
      tmo_cnt          <= '0;
      vtx              <= '0;
      w_q              <= '0;
      ef_a_o           <= '0;
      ef_b_o           <= '0;
      ef_c_o           <= '0;
      ef_exec_strobe_o <= 1'b0;
      busy_o           <= 1'b0;
      inside_o         <= 1'b0;
      error_o          <= 1'b0;
      done_strobe_o    <= 1'b0;
    end else begin
      ef_exec_strobe_o <= 1'b0;
      done_strobe_o    <= 1'b0;
      case (state)
        IDLE: if (start_strobe_i) begin
          vtx              <= {v2_i, v1_i, v0_i};
          // job0 operands come straight from the ports so exec fires in ISSUE
          ef_a_o           <= v1_i;
          ef_b_o           <= v2_i;
          ef_c_o           <= p_i;
          ef_exec_strobe_o <= 1'b1;
          job              <= 2'd0;
          busy_o           <= 1'b1;
          w_q              <= '0;
          inside_o         <= 1'b0;
          error_o          <= 1'b0;
          state            <= ISSUE;
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (ef_done_strobe_i) begin
            w_q[job] <= ef_z_i;
            state    <= NEXT;
          end else if (tmo_cnt == TMO_LAST) begin
            error_o <= 1'b1;
            state   <= FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        NEXT: begin
          if (job == 2'd2) begin
            state <= FINISH;
          end else begin
            job              <= job + 2'd1;
            ef_exec_strobe_o <= 1'b1;
            state            <= ISSUE;
            if (job == 2'd0) begin
              ef_a_o <= vtx[2];
              ef_b_o <= vtx[0];
            end else begin
              ef_a_o <= vtx[0];
              ef_b_o <= vtx[1];
            end
          end
        end
        FINISH: begin
          inside_o      <= inside_calc;
          done_strobe_o <= 1'b1;
          busy_o        <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_setup_sequencer.sv
// Randomized bench for edge_setup_sequencer with a behavioural edge_function model
// (configurable latency) and a real-arithmetic coverage reference.
module tb_edge_setup_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_i, start_strobe_i;
  logic [1:0][31:0] v0_i, v1_i, v2_i, p_i;
  logic [31:0]      ef_z_i;
  logic             ef_done_strobe_i;

  logic             busy_o, ef_exec_strobe_o, inside_o, error_o, done_strobe_o;
  logic [1:0][31:0] ef_a_o, ef_b_o, ef_c_o;
  logic [31:0]      w0_o, w1_o, w2_o;

  logic             busy_n, exec_n, inside_n, error_n, done_n;
  logic [1:0][31:0] ef_a_n, ef_b_n, ef_c_n;
  logic [31:0]      w0_n, w1_n, w2_n;

  edge_setup_sequencer #(.TIMEOUT_CYCLES(16), .INCLUSIVE_ZERO(1'b1)) dut (
    .clk(clk), .reset_i(reset_i), .start_strobe_i(start_strobe_i),
    .v0_i(v0_i), .v1_i(v1_i), .v2_i(v2_i), .p_i(p_i), .busy_o(busy_o),
    .ef_a_o(ef_a_o), .ef_b_o(ef_b_o), .ef_c_o(ef_c_o), .ef_exec_strobe_o(ef_exec_strobe_o),
    .ef_z_i(ef_z_i), .ef_done_strobe_i(ef_done_strobe_i),
    .w0_o(w0_o), .w1_o(w1_o), .w2_o(w2_o), .inside_o(inside_o), .error_o(error_o),
    .done_strobe_o(done_strobe_o));

  edge_setup_sequencer #(.TIMEOUT_CYCLES(16), .INCLUSIVE_ZERO(1'b0)) dut_nz (
    .clk(clk), .reset_i(reset_i), .start_strobe_i(start_strobe_i),
    .v0_i(v0_i), .v1_i(v1_i), .v2_i(v2_i), .p_i(p_i), .busy_o(busy_n),
    .ef_a_o(ef_a_n), .ef_b_o(ef_b_n), .ef_c_o(ef_c_n), .ef_exec_strobe_o(exec_n),
    .ef_z_i(ef_z_i), .ef_done_strobe_i(ef_done_strobe_i),
    .w0_o(w0_n), .w1_o(w1_n), .w2_o(w2_n), .inside_o(inside_n), .error_o(error_n),
    .done_strobe_o(done_n));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] f32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real r32(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    real z;
    z = 0.0;
    if (f[30:0] == 31'd0) return f[31] ? -z : z;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic real edge_r(input real ax, ay, bx, by, cx, cy);
    return (cx - ax) * (by - ay) - (cy - ay) * (bx - ax);
  endfunction

  // edge_function model: result appears lat cycles after the exec cycle
  int lat = 4, pend = 0, exec_cnt = 0;
  bit no_done = 0, inject = 0, hold_ok = 1, nz_sync = 1;
  logic [1:0][31:0] ca, cb, cc;

  initial begin
    ef_done_strobe_i = 1'b0;
    ef_z_i = '0;
    forever begin
      @(negedge clk);
      ef_done_strobe_i = 1'b0;
      if (exec_n !== ef_exec_strobe_o) nz_sync = 0;
      if (pend > 0) begin
        if (ef_a_o !== ca || ef_b_o !== cb || ef_c_o !== cc) hold_ok = 0;
        pend--;
        if (pend == 0) begin
          ef_done_strobe_i = 1'b1;
          ef_z_i = f32(edge_r(r32(ca[0]), r32(ca[1]), r32(cb[0]), r32(cb[1]),
                              r32(cc[0]), r32(cc[1])));
        end
      end
      if (inject) begin
        ef_done_strobe_i = 1'b1;
        ef_z_i = 32'h4120_0000;
        inject = 0;
      end
      if (ef_exec_strobe_o) begin
        exec_cnt++;
        ca = ef_a_o; cb = ef_b_o; cc = ef_c_o;
        if (!no_done) pend = lat;
      end
    end
  end

  real tx[3], ty[3], qx, qy;

  task automatic drive_ops();
    v0_i = {f32(ty[0]), f32(tx[0])};
    v1_i = {f32(ty[1]), f32(tx[1])};
    v2_i = {f32(ty[2]), f32(tx[2])};
    p_i  = {f32(qy), f32(qx)};
  endtask

  // Called at a negedge; issues start in that cycle and returns at the done cycle's negedge.
  task automatic run(input string nm, input int l, input bit glitch, input bit tmo);
    int n, ex0;
    real w0, w1, w2;
    bit in_inc, in_nz;
    lat = l; no_done = tmo; hold_ok = 1; ex0 = exec_cnt;
    drive_ops();
    start_strobe_i = 1'b1;
    @(negedge clk);
    start_strobe_i = 1'b0;
    n = 1;
    chk({nm, "_busy_on"}, {31'd0, busy_o}, 32'd1);
    chk({nm, "_done_low"}, {31'd0, done_strobe_o}, 32'd0);
    chk({nm, "_clr"}, {29'd0, error_o, inside_o, |w0_o}, 32'd0);
    while (!done_strobe_o && n < 400) begin
      if (glitch && n == 3) begin
        start_strobe_i = 1'b1;
        v0_i = {32'h42c8_0000, 32'h42c8_0000};
      end else start_strobe_i = 1'b0;
      @(negedge clk);
      n++;
    end
    start_strobe_i = 1'b0;
    chk({nm, "_done_seen"}, {31'd0, done_strobe_o}, 32'd1);
    chk({nm, "_busy_off"}, {30'd0, busy_o, busy_n}, 32'd0);
    chk({nm, "_nz_done"}, {31'd0, done_n}, 32'd1);
    if (tmo) begin
      chk({nm, "_to_lat"}, {31'd0, (n - 1 >= 16 && n - 1 <= 20)}, 32'd1);
      chk({nm, "_to_err"}, {30'd0, error_o, error_n}, 32'd3);
      chk({nm, "_to_in"}, {30'd0, inside_o, inside_n}, 32'd0);
      chk({nm, "_to_w"}, w0_o | w1_o | w2_o, 32'd0);
      chk({nm, "_to_exec"}, exec_cnt - ex0, 32'd1);
    end else begin
      w0 = edge_r(tx[1], ty[1], tx[2], ty[2], qx, qy);
      w1 = edge_r(tx[2], ty[2], tx[0], ty[0], qx, qy);
      w2 = edge_r(tx[0], ty[0], tx[1], ty[1], qx, qy);
      in_inc = (w0 >= 0.0 && w1 >= 0.0 && w2 >= 0.0) || (w0 <= 0.0 && w1 <= 0.0 && w2 <= 0.0);
      in_nz  = (w0 > 0.0 && w1 > 0.0 && w2 > 0.0) || (w0 < 0.0 && w1 < 0.0 && w2 < 0.0);
      chk({nm, "_lat"}, n - 1, 3 * (l + 2) + 1);
      chk({nm, "_w0"}, w0_o, f32(w0));
      chk({nm, "_w1"}, w1_o, f32(w1));
      chk({nm, "_w2"}, w2_o, f32(w2));
      chk({nm, "_inside"}, {31'd0, inside_o}, {31'd0, in_inc});
      chk({nm, "_inside_nz"}, {31'd0, inside_n}, {31'd0, in_nz});
      chk({nm, "_err"}, {30'd0, error_o, error_n}, 32'd0);
      chk({nm, "_exec3"}, exec_cnt - ex0, 32'd3);
      chk({nm, "_hold"}, {31'd0, hold_ok}, 32'd1);
      chk({nm, "_nz_ops"}, {31'd0, {ef_a_n, ef_b_n, ef_c_n} !== {ef_a_o, ef_b_o, ef_c_o}}, 32'd0);
    end
  endtask

  task automatic set_tri(input real x0, y0, x1, y1, x2, y2, px, py);
    tx[0] = x0; ty[0] = y0; tx[1] = x1; ty[1] = y1; tx[2] = x2; ty[2] = y2;
    qx = px; qy = py;
  endtask

  initial begin
    int dn, ex0;
    logic [31:0] s0, s1, s2;
    logic s_in, s_er;
    reset_i = 1'b1;
    start_strobe_i = 1'b0;
    v0_i = '0; v1_i = '0; v2_i = '0; p_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {27'd0, busy_o, ef_exec_strobe_o, inside_o, error_o, done_strobe_o}, 32'd0);
    chk("rst_w", w0_o | w1_o | w2_o, 32'd0);
    chk("rst_ops", {31'd0, |{ef_a_o, ef_b_o, ef_c_o}}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);

    set_tri(0.0, 0.0, 2.0, 0.0, 0.0, 2.0, 0.5, 0.5);
    run("c1", 4, 0, 0);
    chk("c1_w0k", w0_o, 32'hc000_0000);
    chk("c1_w1k", w1_o, 32'hbf80_0000);
    chk("c1_w2k", w2_o, 32'hbf80_0000);
    @(negedge clk);
    set_tri(0.0, 0.0, 2.0, 0.0, 0.0, 2.0, 3.0, 3.0);
    run("c2", 4, 0, 0);
    chk("c2_w0k", w0_o, 32'h4100_0000);
    chk("c2_w2k", w2_o, 32'hc0c0_0000);
    chk("c2_ink", {31'd0, inside_o}, 32'd0);
    @(negedge clk);
    set_tri(0.0, 0.0, 2.0, 0.0, 0.0, 2.0, 1.0, 1.0);
    run("c3", 4, 0, 0);
    chk("c3_zero", {1'b0, w0_o[30:0]}, 32'd0);
    chk("c3_ink", {30'd0, inside_o, inside_n}, 32'd2);

    // start pulsed while waiting on a job must be dropped
    @(negedge clk);
    set_tri(0.0, 0.0, 2.0, 0.0, 0.0, 2.0, 0.5, 0.5);
    run("glitch", 4, 1, 0);

    // stray done while idle
    repeat (2) @(negedge clk);
    s0 = w0_o; s1 = w1_o; s2 = w2_o; s_in = inside_o; s_er = error_o;
    inject = 1;
    dn = 0;
    repeat (4) begin @(negedge clk); dn += int'(done_strobe_o); end
    chk("idle_done_w", {w0_o ^ s0} | {w1_o ^ s1} | {w2_o ^ s2}, 32'd0);
    chk("idle_done_flags", {29'd0, inside_o ^ s_in, error_o ^ s_er, busy_o}, 32'd0);
    chk("idle_done_pulse", dn, 32'd0);

    set_tri(0.0, 0.0, 2.0, 0.0, 0.0, 2.0, 0.5, 0.5);
    run("tmo", 4, 0, 1);
    dn = 0;
    repeat (30) begin @(negedge clk); dn += int'(done_strobe_o); end
    chk("tmo_single", dn, 32'd0);
    run("after_tmo", 3, 0, 0);

    // reset during the job1 wait; the model's pending done arrives afterwards
    @(negedge clk);
    lat = 4; no_done = 0;
    drive_ops();
    start_strobe_i = 1'b1;
    @(negedge clk);
    start_strobe_i = 1'b0;
    repeat (7) @(negedge clk);
    chk("midrst_busy", {31'd0, busy_o}, 32'd1);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("midrst_ctl", {27'd0, busy_o, ef_exec_strobe_o, inside_o, error_o, done_strobe_o}, 32'd0);
    chk("midrst_w", w0_o | w1_o | w2_o, 32'd0);
    chk("midrst_ops", {31'd0, |{ef_a_o, ef_b_o, ef_c_o}}, 32'd0);
    ex0 = exec_cnt; dn = 0;
    repeat (20) begin @(negedge clk); dn += int'(done_strobe_o) + int'(busy_o); end
    chk("midrst_quiet", dn, 32'd0);
    chk("midrst_noexec", exec_cnt - ex0, 32'd0);
    chk("midrst_w_after", w0_o | w1_o | w2_o, 32'd0);

    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < 3; k++) begin
        tx[k] = real'(int'($urandom_range(32, 0)) - 16) / 2.0;
        ty[k] = real'(int'($urandom_range(32, 0)) - 16) / 2.0;
      end
      qx = real'(int'($urandom_range(32, 0)) - 16) / 2.0;
      qy = real'(int'($urandom_range(32, 0)) - 16) / 2.0;
      if ($urandom_range(1, 0) == 1) repeat ($urandom_range(3, 1)) @(negedge clk);
      run("rnd", int'($urandom_range(8, 1)), 0, 0);
    end
    chk("nz_sync", {31'd0, nz_sync}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
